// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the flexible synchronous FIFO and its pointers.
package fifo_pkg;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; a depth of 1 or 2 still needs a one-bit pointer.
  function automatic int addr_width(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Storage pointer that wraps at DEPTH-1 by explicit compare, so that
// storage depths which are not a power of two are handled correctly.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         inc,
  output logic [addr_width(DEPTH)-1:0] ptr
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Next pointer: advance on inc, returning to 0 after the last entry.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register; reset takes priority over clear, and clear over advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock ready/valid FIFO with any depth >= 2, programmable
// almost-full / almost-empty watermarks, synchronous flush and occupancy.
// Optional peak-occupancy tracker enabled by defining FIFO_SYNC_FLEX_PEAK_EN.
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 12,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [CNT_W-1:0] af_thresh,
  input  logic [CNT_W-1:0] ae_thresh,
`ifdef FIFO_SYNC_FLEX_PEAK_EN
  input  logic             peak_clr,
  output logic [CNT_W-1:0] peak,
`endif
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wptr, rptr;
  logic              push, pop;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  // Handshake gating; flush blocks both sides so nothing moves on a flush edge.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data     = mem_q[rptr];
  assign count        = count_q;
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rptr)
  );

  // Occupancy next-state; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy register with reset, then flush, then push/pop priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wptr] <= in_data;
    end
  end

`ifdef FIFO_SYNC_FLEX_PEAK_EN
  logic [CNT_W-1:0] peak_q;

  // High-water mark of occupancy; survives flush, reloads from count on clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (peak_clr) begin
      peak_q <= count_q;
    end else if (count_q > peak_q) begin
      peak_q <= count_q;
    end
  end

  assign peak = peak_q;
`endif

endmodule
